svga_timing_gen: RTL and testbench

- Produces the SVGA 800x600@56 Hz raster: pixel coordinates, sync pulses, the active-video flag and frame/line strobes.
- Downstream tile renderers consume `h_coord`/`v_coord` and return RGB.
- Sync and `display_on` are delayed by a parameterised number of cycles so that they line up with the renderer's registered ROM/mask output.
- Runs on the 36 MHz pixel clock.

---
 rtl/svga_timing_gen.sv | 176 +++++++++++++++++
 tb/tb_svga_timing_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/svga_timing_gen.sv
// svga_timing_gen: SVGA 800x600@56 Hz raster generator on the 36 MHz pixel clock.
// Produces pixel coordinates, line/frame/end-of-active strobes and sync/active-video
// flags delayed by SYNC_DELAY cycles to line up with registered renderer output.
// Optional feature macro: SVGA_FRAME_CNT_EN enables the 16-bit frame counter;
// without it frame_cnt is tied to zero but the port remains.
module svga_timing_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 72,
  parameter int H_BP       = 128,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 22,
  parameter bit SYNC_POL   = 1'b1,
  parameter int SYNC_DELAY = 1
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  output logic [10:0] h_coord,
  output logic [9:0]  v_coord,
  output logic        hsync,
  output logic        vsync,
  output logic        display_on,
  output logic        line_start,
  output logic        frame_start,
  output logic        end_of_active,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // All decode constants are sized to the counter widths so every compare is 11/10-bit.
  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT        = 11'(H_ACTIVE);
  localparam logic [10:0] H_ACT_LAST   = 11'(H_ACTIVE - 1);
  localparam logic [10:0] H_SYNC_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0]  V_ACT_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Refuse to elaborate with timings that overflow the coordinate widths.
  if (H_TOTAL > 2048 || H_TOTAL < 1) begin : g_bad_h_total
    $error("svga_timing_gen: H_TOTAL must be 1..2048");
  end
  if (V_TOTAL > 1024 || V_TOTAL < 1) begin : g_bad_v_total
    $error("svga_timing_gen: V_TOTAL must be 1..1024");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
    $error("svga_timing_gen: SYNC_DELAY must be 0..4");
  end

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;

  // Next-state for the raster counters: h wraps every line, v advances on the h wrap.
  always_comb begin
    h_d = h_q + 11'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d = '0;
      end else begin
        v_d = v_q + 10'd1;
      end
    end
  end

  // Raster counter registers; reset parks them at the top-left pixel.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_coord = h_q;
  assign v_coord = v_q;

  logic hs_raw, vs_raw, de_raw;
  logic [2:0] raw_vec;
  logic [2:0] out_vec;

  // Undelayed decode; gated by rst_n so the zero-delay build is inactive during reset.
  always_comb begin
    hs_raw  = rst_n && (h_q >= H_SYNC_FIRST) && (h_q <= H_SYNC_LAST);
    vs_raw  = rst_n && (v_q >= V_SYNC_FIRST) && (v_q <= V_SYNC_LAST);
    de_raw  = rst_n && (h_q < H_ACT) && (v_q < V_ACT);
    raw_vec = {hs_raw, vs_raw, de_raw};
  end

  if (SYNC_DELAY == 0) begin : g_no_delay
    assign out_vec = raw_vec;
  end else begin : g_delay
    logic [2:0] pipe_q [SYNC_DELAY];
    logic [2:0] pipe_d [SYNC_DELAY];

    // Shift the raw flags one stage per cycle; stage 0 takes the fresh decode.
    always_comb begin
      pipe_d[0] = raw_vec;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    // Every stage clears to the inactive value so no stale pulse survives a reset.
    always_ff @(posedge pixel_clk) begin
      if (!rst_n) begin
        for (int i = 0; i < SYNC_DELAY; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < SYNC_DELAY; i++) begin
          pipe_q[i] <= pipe_d[i];
        end
      end
    end

    assign out_vec = pipe_q[SYNC_DELAY-1];
  end

  // Map the active-high internal flags to the configured sync polarity.
  always_comb begin
    hsync      = ~(out_vec[2] ^ SYNC_POL);
    vsync      = ~(out_vec[1] ^ SYNC_POL);
    display_on = out_vec[0];
  end

  // Strobes track the live counters and are suppressed while reset is held.
  always_comb begin
    line_start    = rst_n && (h_q == 11'd0);
    frame_start   = rst_n && (h_q == 11'd0) && (v_q == 10'd0);
    end_of_active = rst_n && (h_q == H_ACT_LAST) && (v_q == V_ACT_LAST);
  end

`ifdef SVGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        armed_q, armed_d;

  // Count frame starts, skipping the one that immediately follows reset release.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    armed_d     = armed_q;
    if (frame_start) begin
      armed_d = 1'b1;
      if (armed_q) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end
  end

  // Frame counter registers; wraps naturally at 16 bits.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      armed_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      armed_q     <= armed_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_svga_timing_gen.sv
// tb_svga_timing_gen: directed checks of svga_timing_gen with SYNC_DELAY 0, 1 and 2.
// Long stretches of the raster are skipped by loading the counter registers directly.
module tb_svga_timing_gen;

  logic clk = 1'b0;
  logic rstN;

  logic [10:0] hCoord0, hCoord1, hCoord2;
  logic [9:0]  vCoord0, vCoord1, vCoord2;
  logic        hsync0, hsync1, hsync2;
  logic        vsync0, vsync1, vsync2;
  logic        de0, de1, de2;
  logic        ls0, ls1, ls2;
  logic        fs0, fs1, fs2;
  logic        eoa0, eoa1, eoa2;
  logic [15:0] fc0, fc1, fc2;

  logic [10:0] hJump;
  logic [9:0]  vJump;

  int nChecked = 0;
  int nFailed  = 0;

  typedef struct {
    int h; int v;
    bit hs0; bit hs1; bit hs2;
    bit vs0; bit vs1;
    bit de0; bit de1;
    bit ls; bit fs; bit eoa;
  } vec_t;

  vec_t vecs[$];

  // 36 MHz-ish pixel clock; exact period is irrelevant to the checks.
  always #5 clk = ~clk;

  svga_timing_gen #(.SYNC_DELAY(0)) dut_d0 (
    .pixel_clk(clk), .rst_n(rstN), .h_coord(hCoord0), .v_coord(vCoord0),
    .hsync(hsync0), .vsync(vsync0), .display_on(de0), .line_start(ls0),
    .frame_start(fs0), .end_of_active(eoa0), .frame_cnt(fc0));

  svga_timing_gen dut_d1 (
    .pixel_clk(clk), .rst_n(rstN), .h_coord(hCoord1), .v_coord(vCoord1),
    .hsync(hsync1), .vsync(vsync1), .display_on(de1), .line_start(ls1),
    .frame_start(fs1), .end_of_active(eoa1), .frame_cnt(fc1));

  svga_timing_gen #(.SYNC_DELAY(2)) dut_d2 (
    .pixel_clk(clk), .rst_n(rstN), .h_coord(hCoord2), .v_coord(vCoord2),
    .hsync(hsync2), .vsync(vsync2), .display_on(de2), .line_start(ls2),
    .frame_start(fs2), .end_of_active(eoa2), .frame_cnt(fc2));

  // Compare one value and log a FAIL line on mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecked++;
    if (actual != expected) begin
      nFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Load all three DUTs' counters to (h,v); call at a negedge so the load settles before posedge.
  task automatic jumpTo(input int h, input int v);
    hJump = 11'(h);
    vJump = 10'(v);
    force dut_d0.h_q = hJump;
    force dut_d0.v_q = vJump;
    force dut_d1.h_q = hJump;
    force dut_d1.v_q = vJump;
    force dut_d2.h_q = hJump;
    force dut_d2.v_q = vJump;
    #1;
    release dut_d0.h_q;
    release dut_d0.v_q;
    release dut_d1.h_q;
    release dut_d1.v_q;
    release dut_d2.h_q;
    release dut_d2.v_q;
  endtask

  // Land on the vector's coordinate four cycles after a jump so the delay lines hold real history.
  task automatic applyStimulus(input vec_t vec);
    int lin;
    lin = (vec.v * 1024 + vec.h - 4 + 640000) % 640000;
    jumpTo(lin % 1024, lin / 1024);
    repeat (4) @(negedge clk);
    checkOutput("vec h_coord", int'(hCoord1), vec.h);
    checkOutput("vec v_coord", int'(vCoord1), vec.v);
    checkOutput("vec hsync d0", int'(hsync0), int'(vec.hs0));
    checkOutput("vec hsync d1", int'(hsync1), int'(vec.hs1));
    checkOutput("vec hsync d2", int'(hsync2), int'(vec.hs2));
    checkOutput("vec vsync d0", int'(vsync0), int'(vec.vs0));
    checkOutput("vec vsync d1", int'(vsync1), int'(vec.vs1));
    checkOutput("vec display_on d0", int'(de0), int'(vec.de0));
    checkOutput("vec display_on d1", int'(de1), int'(vec.de1));
    checkOutput("vec line_start", int'(ls1), int'(vec.ls));
    checkOutput("vec frame_start", int'(fs1), int'(vec.fs));
    checkOutput("vec end_of_active", int'(eoa1), int'(vec.eoa));
  endtask

  initial begin
    int cnt;
    int guard;

    //                 h    v   hs0 hs1 hs2 vs0 vs1 de0 de1 ls fs eoa
    vecs.push_back('{ 823,  10,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0});
    vecs.push_back('{ 824,  10,  1,  0,  0,  0,  0,  0,  0,  0, 0, 0});
    vecs.push_back('{ 826,  10,  1,  1,  1,  0,  0,  0,  0,  0, 0, 0});
    vecs.push_back('{ 895,  10,  1,  1,  1,  0,  0,  0,  0,  0, 0, 0});
    vecs.push_back('{ 896,  10,  0,  1,  1,  0,  0,  0,  0,  0, 0, 0});
    vecs.push_back('{ 897,  10,  0,  0,  1,  0,  0,  0,  0,  0, 0, 0});
    vecs.push_back('{ 898,  10,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0});
    vecs.push_back('{ 799,  10,  0,  0,  0,  0,  0,  1,  1,  0, 0, 0});
    vecs.push_back('{ 800,  10,  0,  0,  0,  0,  0,  0,  1,  0, 0, 0});
    vecs.push_back('{ 801,  10,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0});
    vecs.push_back('{ 500, 600,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0});
    vecs.push_back('{ 500, 601,  0,  0,  0,  1,  1,  0,  0,  0, 0, 0});
    vecs.push_back('{ 500, 602,  0,  0,  0,  1,  1,  0,  0,  0, 0, 0});
    vecs.push_back('{ 500, 603,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0});
    vecs.push_back('{   0, 601,  0,  0,  0,  1,  0,  0,  0,  1, 0, 0});
    vecs.push_back('{   0, 603,  0,  0,  0,  0,  1,  0,  0,  1, 0, 0});
    vecs.push_back('{   5, 599,  0,  0,  0,  0,  0,  1,  1,  0, 0, 0});
    vecs.push_back('{ 799, 599,  0,  0,  0,  0,  0,  1,  1,  0, 0, 1});
    vecs.push_back('{ 800, 599,  0,  0,  0,  0,  0,  0,  1,  0, 0, 0});
    vecs.push_back('{ 799, 600,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0});
    vecs.push_back('{1023, 624,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0});
    vecs.push_back('{   0,   0,  0,  0,  0,  0,  0,  1,  0,  1, 1, 0});
    vecs.push_back('{   1,   0,  0,  0,  0,  0,  0,  1,  1,  0, 0, 0});
    vecs.push_back('{   0,   1,  0,  0,  0,  0,  0,  1,  0,  1, 0, 0});

    // Reset state: everything inactive, no strobes while rst_n is low.
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst h_coord", int'(hCoord1), 0);
    checkOutput("rst v_coord", int'(vCoord1), 0);
    checkOutput("rst hsync d0", int'(hsync0), 0);
    checkOutput("rst hsync d1", int'(hsync1), 0);
    checkOutput("rst vsync d2", int'(vsync2), 0);
    checkOutput("rst display_on d0", int'(de0), 0);
    checkOutput("rst display_on d1", int'(de1), 0);
    checkOutput("rst line_start", int'(ls1), 0);
    checkOutput("rst frame_start", int'(fs1), 0);
    checkOutput("rst frame_cnt", int'(fc1), 0);

    // First cycle after release holds (0,0) with both strobes; next cycle advances.
    rstN = 1'b1;
    #1;
    checkOutput("rel h_coord", int'(hCoord1), 0);
    checkOutput("rel frame_start", int'(fs1), 1);
    checkOutput("rel line_start", int'(ls1), 1);
    checkOutput("rel display_on d0", int'(de0), 1);
    checkOutput("rel display_on d1", int'(de1), 0);
    @(negedge clk);
    checkOutput("rel+1 h_coord", int'(hCoord1), 1);
    checkOutput("rel+1 frame_start", int'(fs1), 0);
    checkOutput("rel+1 line_start", int'(ls1), 0);
    checkOutput("rel+1 display_on d1", int'(de1), 1);
    checkOutput("rel+1 display_on d2", int'(de2), 0);
    @(negedge clk);
    checkOutput("rel+2 display_on d2", int'(de2), 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
    end

    // end_of_active must be a single-cycle pulse.
    @(negedge clk);
    jumpTo(797, 599);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (eoa1) cnt++;
    end
    checkOutput("eoa pulse width", cnt, 1);

    // Line period between consecutive line_start strobes.
    guard = 0;
    while (!ls1 && guard < 1100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("first line_start seen", int'(ls1), 1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!ls1 && cnt < 1100);
    checkOutput("line period", cnt, 1024);

    // Mid-frame reset clears counters and delay lines; no stale display_on afterwards.
    jumpTo(496, 300);
    repeat (4) @(negedge clk);
    checkOutput("pre-rst display_on d2", int'(de2), 1);
    rstN = 1'b0;
    #1;
    checkOutput("mid-rst frame_start", int'(fs1), 0);
    repeat (3) @(negedge clk);
    checkOutput("mid-rst h_coord", int'(hCoord1), 0);
    checkOutput("mid-rst v_coord", int'(vCoord1), 0);
    checkOutput("mid-rst hsync d1", int'(hsync1), 0);
    checkOutput("mid-rst vsync d1", int'(vsync1), 0);
    checkOutput("mid-rst display_on d2", int'(de2), 0);
    checkOutput("mid-rst line_start", int'(ls1), 0);
    checkOutput("mid-rst frame_start", int'(fs1), 0);
    rstN = 1'b1;
    #1;
    checkOutput("mid-rel frame_start", int'(fs1), 1);
    checkOutput("mid-rel display_on d1", int'(de1), 0);
    checkOutput("mid-rel display_on d2", int'(de2), 0);
    @(negedge clk);
    checkOutput("mid-rel+1 display_on d2", int'(de2), 0);
    checkOutput("mid-rel+1 display_on d1", int'(de1), 1);

`ifdef SVGA_FRAME_CNT_EN
    // Post-reset frame_start is not counted; later ones are, and the count wraps.
    checkOutput("fc after reset", int'(fc1), 0);
    jumpTo(1020, 624);
    repeat (5) @(negedge clk);
    checkOutput("fc frame 2", int'(fc1), 1);
    jumpTo(1020, 624);
    repeat (5) @(negedge clk);
    checkOutput("fc frame 3", int'(fc1), 2);
    force dut_d1.frame_cnt_q = 16'hFFFF;
    #1;
    release dut_d1.frame_cnt_q;
    @(negedge clk);
    jumpTo(1020, 624);
    repeat (5) @(negedge clk);
    checkOutput("fc wrap", int'(fc1), 0);
`else
    // Counter disabled: port stays at zero across frame boundaries.
    jumpTo(1020, 624);
    repeat (5) @(negedge clk);
    checkOutput("fc disabled d1", int'(fc1), 0);
    checkOutput("fc disabled d2", int'(fc2), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecked, nFailed);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
